if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage. It drives the PC into the synchronous instruction memory and supplies the `if_pc` / `if_instruction` pair consumed by `if_id_pipeline`.
- Instruction memory output is registered, so `if_pc` leads `if_instruction` by one cycle. The `if_id_pipeline` register realigns them.
- Handles reset boot, stall hold, redirect (branch/jump) and squash of the wrong-path fetch in flight.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INSTR, 32'h00000013, bubble injected on squash (addi x0,x0,0).
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hazard unit: hold fetch.
- redirect_valid  in  1  taken branch/jump from EX.
- redirect_pc  in  32  redirect target.
- imem_addr  out  32  address to instruction memory, sampled by memory at posedge.
- imem_en  out  1  memory read enable; memory holds rdata when 0.
- imem_rdata  in  32  registered memory data (address of previous enabled cycle).
- if_pc  out  32  PC of fetch issued this cycle (= imem_addr).
- if_instruction  out  32  instruction for the PC presented last enabled cycle, or NOP_INSTR.
- if_valid  out  1  if_instruction is a real, non-squashed instruction.

Behaviour:
- Registers:
  - `pc_q` (32), reset RESET_PC.
  - State `fsm_q` ∈ {S_BOOT, S_RUN, S_SQUASH}, reset S_BOOT.
- Combinational outputs:
  - `imem_addr = if_pc = pc_q`.
  - `imem_en = ~stall | redirect_valid`.
  - `if_instruction = (fsm_q==S_RUN) ? imem_rdata : NOP_INSTR`.
  - `if_valid = (fsm_q==S_RUN)`.
- Values during reset (rst_n=0):
  - `pc_q`=RESET_PC, state S_BOOT.
  - `if_pc`=RESET_PC, `if_instruction`=NOP_INSTR, `if_valid`=0, `imem_en`=1.
- Priority each posedge: redirect_valid > stall > advance.
  - Redirect: `pc_q <= {redirect_pc[31:2],2'b00}`; `fsm_q <= S_SQUASH`. The fetch at old `pc_q` is wrong-path; its data is masked next cycle. Redirect during stall overrides stall.
  - Stall, no redirect: `pc_q` and `fsm_q` hold; `imem_en`=0, so `imem_rdata` stays stable and the output pair is unchanged.
  - Advance: `pc_q <= pc_q + PC_STEP`, mod 2^32 (0xFFFFFFFC wraps to 0); `fsm_q <= S_RUN`.
- State transitions:
  - S_BOOT → S_RUN on the first non-stalled edge. Memory data is invalid before the first fetch.
  - S_SQUASH → S_RUN on the next non-stalled edge. Stall holds S_SQUASH.
  - Back-to-back redirects stay in S_SQUASH with the newest target.
- Latency: instruction for PC p appears on `if_instruction` the cycle after p is on `if_pc`, given no stall/redirect at that edge.
- Scope: the fetch unit squashes only its own in-flight fetch. Flushing IF/ID and ID/EX contents on redirect belongs to the hazard unit.
- Reset mid-operation: asynchronous return to reset values; no pending redirect survives.
- Redirect target low bits: `redirect_pc[1:0]` ignored, forced 0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds output port `fetch_count` (out, 32), a counter of delivered instructions.
  - Increments at posedge when `if_valid & ~stall & ~redirect_valid`; wraps at 2^32.
  - Reset 0.
- When undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package `riscv_pkg` holds:
  - Fetch state encoding (S_BOOT=2'd0, S_RUN=2'd1, S_SQUASH=2'd2).
  - NOP_INSTR constant.
  - XLEN=32.
- One natural sub-module, `fetch_pc_gen`: `pc_q` register and next-PC mux (redirect/stall/increment/align).
- State register and output masking stay in the top.

Test Plan:
- Reset release, no stall, memory returns addr-tagged data (rdata = addr ^ 32'hA5A5A5A5):
  - Cycle 0: if_pc=0, if_valid=0, if_instruction=0x00000013.
  - Cycle 1: if_pc=4, if_instruction=0xA5A5A5A5, if_valid=1.
  - Cycle 2: if_pc=8.
- Stall for 3 cycles at if_pc=0x10:
  - imem_en=0; if_pc stays 0x10; if_instruction holds the data for 0x0C.
  - After release: 0x14 presented, data for 0x10 delivered.
- Redirect to 0x200 while if_pc=0x20:
  - Next cycle: if_pc=0x200, if_instruction=NOP, if_valid=0.
  - Following cycle: data for 0x200 delivered, if_pc=0x204.
- Redirect with stall=1 simultaneously, target 0x103: if_pc=0x100 next cycle; stall ignored for that edge.
- Wrap: redirect to 0xFFFFFFFC, then advance → if_pc=0x00000000.
- FETCH_PERF_CNT_EN: 5 valid deliveries, 2 stall cycles, 1 redirect → fetch_count=5. Assert rst_n low mid-run → fetch_count=0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: data width, bubble encoding and
// the fetch state machine encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_SQUASH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC selection.
// Priority per edge: redirect (word-aligned target) > stall (hold) > increment.
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_q
);

  logic [XLEN-1:0] pc_d;

  // Target low bits carry no meaning for 32-bit aligned fetch.
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^redirect_pc[1:0];

  // Next-PC mux; increment wraps naturally modulo 2^XLEN.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (!stall)
      pc_d = pc_q + XLEN'(PC_STEP);
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Issues pc_q to a synchronous instruction memory
// and masks the returned data until it belongs to a real, on-path fetch
// (after boot and after a redirect). if_pc leads if_instruction by one cycle.
// Optional build macro: FETCH_PERF_CNT_EN adds the fetch_count output.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR,
  parameter int              PC_STEP   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instruction,
  output logic            if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count
`endif
);

  fetch_state_e    fsm_q, fsm_d;
  logic [XLEN-1:0] pc_q;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_q           (pc_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= S_BOOT;
    else        fsm_q <= fsm_d;
  end

  // Next state: a redirect squashes the in-flight fetch; any other
  // non-stalled edge makes the next memory word an on-path instruction.
  always_comb begin
    fsm_d = fsm_q;
    if (redirect_valid)
      fsm_d = S_SQUASH;
    else if (!stall)
      fsm_d = S_RUN;
  end

  // Memory interface and output masking. A redirect must still fetch the
  // new target, so it overrides the stall on the read enable.
  always_comb begin
    imem_addr      = pc_q;
    if_pc          = pc_q;
    imem_en        = ~stall | redirect_valid;
    if_valid       = (fsm_q == S_RUN);
    if_instruction = (fsm_q == S_RUN) ? imem_rdata : NOP_INSTR;
  end

`ifdef FETCH_PERF_CNT_EN
  // Count instructions actually handed downstream on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= '0;
    else if (if_valid && !stall && !redirect_valid)
      fetch_count <= fetch_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed plan sequence followed by
// random stall/redirect traffic, checked against an abstract fetch model.
module tb_if_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] TAG  = 32'hA5A5_A5A5;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_valid       (if_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory returning address-tagged words.
  always @(posedge clk) if (imem_en) imem_rdata <= imem_addr ^ TAG;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        en;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model: next address to fetch, whether the word now in the
  // memory register is a real on-path instruction, its address, and count.
  logic [31:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_last = '0;
  logic [31:0] m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("if_pc", if_pc, mon_e.pc);
      chk("imem_addr", imem_addr, mon_e.pc);
      chk("if_instruction", if_instruction, mon_e.instr);
      chk("if_valid", {31'b0, if_valid}, {31'b0, mon_e.valid});
      chk("imem_en", {31'b0, imem_en}, {31'b0, mon_e.en});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, mon_e.cnt);
`endif
    end
  end

  // One cycle of stimulus: drive inputs, push the expected view of this
  // cycle, then advance the model across the clock edge.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    exp_t e;
    stall = s; redirect_valid = r; redirect_pc = t;
    e.pc    = m_pc;
    e.valid = m_valid;
    e.instr = m_valid ? (m_last ^ TAG) : NOPI;
    e.en    = ~s | r;
    e.cnt   = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_pc    = t & 32'hFFFF_FFFC;
    end else if (!s) begin
      if (m_valid) m_cnt = m_cnt + 1;
      m_valid = 1'b1;
      m_last  = m_pc;
      m_pc    = m_pc + 4;
    end
    #1;
  endtask

  task automatic check_reset_state(input string tagn);
    chk({tagn, "_pc"}, if_pc, 32'h0);
    chk({tagn, "_valid"}, {31'b0, if_valid}, 32'h0);
    chk({tagn, "_instr"}, if_instruction, NOPI);
    chk({tagn, "_en"}, {31'b0, imem_en}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    chk({tagn, "_cnt"}, fetch_count, 32'h0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check_reset_state("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Boot and sequential fetch: 0x0, 0x4, 0x8, 0xC.
    repeat (4) step(1'b0, 1'b0, 32'h0);
    // Three-cycle stall at 0x10, then run to 0x20.
    repeat (3) step(1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    // Redirect to 0x200 from 0x20.
    step(1'b0, 1'b1, 32'h0000_0200);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    // Redirect overrides a simultaneous stall; low target bits dropped.
    step(1'b1, 1'b1, 32'h0000_0103);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    // Wrap past the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    // Back-to-back redirects, stall while squashing.
    step(1'b0, 1'b1, 32'h0000_1000);
    step(1'b0, 1'b1, 32'h0000_2002);
    step(1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // Asynchronous reset mid-run: outputs return at once.
    stall = 1'b0; redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    m_pc = '0; m_valid = 1'b0; m_last = '0; m_cnt = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(s, r, t);
    end
    step(1'b0, 1'b0, 32'h0);

    @(negedge clk); #1;
    chk("sb_drain", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
